// File: rtl/sprite_frame_sync.sv
// Double-buffers player/stage descriptors so they change only at vertical-sync start,
// and runs one frame-granular attack/cooldown FSM per player.
module sprite_frame_sync #(
  parameter int unsigned ATK_FRAMES  = 12,
  parameter int unsigned COOL_FRAMES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic [63:0] p1_desc_in,
  input  logic [63:0] p2_desc_in,
  input  logic [63:0] stage_desc_in,
  input  logic        p1_atk_req,
  input  logic        p2_atk_req,
  output logic [63:0] p1VGA,
  output logic [63:0] p2VGA,
  output logic [63:0] stageVGA,
  output logic        p1_atk_n,
  output logic        p2_atk_n,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int unsigned DESC_W = 64;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned NPL    = 2;
  localparam logic [CNT_W-1:0] ATK_LOAD  = CNT_W'(ATK_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = (COOL_FRAMES == 0) ? '0 : CNT_W'(COOL_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_COOL   = 2'd2
  } state_e;

  logic              vs_q, vs_d;
  logic              boundary_c;
  logic [DESC_W-1:0] p1_q, p1_d, p2_q, p2_d, st_q, st_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              tick_q, tick_d;
  logic [NPL-1:0]    req_c, eff_c;
  logic [NPL-1:0]    pend_q, pend_d;
  logic [NPL-1:0]    atk_n_q, atk_n_d;
  state_e            state_q [NPL];
  state_e            state_d [NPL];
  logic [CNT_W-1:0]  cnt_q   [NPL];
  logic [CNT_W-1:0]  cnt_d   [NPL];

  // Frame boundary is the single cycle in which iVS has just fallen.
  assign boundary_c = vs_q & ~iVS;
  assign req_c      = {p2_atk_req, p1_atk_req};
  assign eff_c      = pend_q | req_c;

  always_comb begin
    vs_d   = iVS;
    p1_d   = p1_q;
    p2_d   = p2_q;
    st_d   = st_q;
    fcnt_d = fcnt_q;
    tick_d = boundary_c;
    if (boundary_c) begin
      p1_d   = p1_desc_in;
      p2_d   = p2_desc_in;
      st_d   = stage_desc_in;
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  // Per-player request latch and attack FSM; everything advances only on the boundary.
  always_comb begin
    for (int p = 0; p < NPL; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      pend_d[p]  = boundary_c ? 1'b0 : (pend_q[p] | req_c[p]);
      if (boundary_c) begin
        case (state_q[p])
          ST_IDLE: begin
            if (eff_c[p]) begin
              state_d[p] = ST_ACTIVE;
              cnt_d[p]   = ATK_LOAD;
            end
          end
          ST_ACTIVE: begin
            if (cnt_q[p] != '0) begin
              cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end else if (COOL_FRAMES == 0) begin
              state_d[p] = ST_IDLE;
            end else begin
              state_d[p] = ST_COOL;
              cnt_d[p]   = COOL_LOAD;
            end
          end
          ST_COOL: begin
            if (cnt_q[p] != '0) begin
              cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end else begin
              state_d[p] = ST_IDLE;
            end
          end
          default: begin
            state_d[p] = ST_IDLE;
            cnt_d[p]   = '0;
          end
        endcase
      end
      atk_n_d[p] = (state_d[p] != ST_ACTIVE);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q    <= 1'b1;
      p1_q    <= '0;
      p2_q    <= '0;
      st_q    <= '0;
      fcnt_q  <= '0;
      tick_q  <= 1'b0;
      pend_q  <= '0;
      atk_n_q <= '1;
      for (int p = 0; p < NPL; p++) begin
        state_q[p] <= ST_IDLE;
        cnt_q[p]   <= '0;
      end
    end else begin
      vs_q    <= vs_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      st_q    <= st_d;
      fcnt_q  <= fcnt_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      atk_n_q <= atk_n_d;
      for (int p = 0; p < NPL; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  assign p1VGA      = p1_q;
  assign p2VGA      = p2_q;
  assign stageVGA   = st_q;
  assign p1_atk_n   = atk_n_q[0];
  assign p2_atk_n   = atk_n_q[1];
  assign frame_tick = tick_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_sprite_frame_sync.sv
// Bench for sprite_frame_sync: default build plus a short-attack, zero-cooldown build,
// both checked every cycle against a frame-index reference model.
module tb_sprite_frame_sync;

  localparam int unsigned ATK0 = 12, COOL0 = 8, ATK1 = 3, COOL1 = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iVS;
  logic [63:0] p1_in, p2_in, st_in;
  logic        r1, r2;

  logic [63:0] a_p1, a_p2, a_st, b_p1, b_p2, b_st;
  logic        a_a1, a_a2, a_tick, b_a1, b_a2, b_tick;
  logic [15:0] a_cnt, b_cnt;

  sprite_frame_sync #(.ATK_FRAMES(ATK0), .COOL_FRAMES(COOL0), .CNT_W(8)) dut_a (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(iVS),
    .p1_desc_in(p1_in), .p2_desc_in(p2_in), .stage_desc_in(st_in),
    .p1_atk_req(r1), .p2_atk_req(r2),
    .p1VGA(a_p1), .p2VGA(a_p2), .stageVGA(a_st),
    .p1_atk_n(a_a1), .p2_atk_n(a_a2), .frame_tick(a_tick), .frame_cnt(a_cnt));

  sprite_frame_sync #(.ATK_FRAMES(ATK1), .COOL_FRAMES(COOL1), .CNT_W(8)) dut_b (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVS(iVS),
    .p1_desc_in(p1_in), .p2_desc_in(p2_in), .stage_desc_in(st_in),
    .p1_atk_req(r1), .p2_atk_req(r2),
    .p1VGA(b_p1), .p2VGA(b_p2), .stageVGA(b_st),
    .p1_atk_n(b_a1), .p2_atk_n(b_a2), .frame_tick(b_tick), .frame_cnt(b_cnt));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an attack started at boundary s owns boundaries s..s+ATK-1 and
  // blocks new starts until boundary s+ATK+COOL+1.
  int          atk_c  [2];
  int          cool_c [2];
  logic        m_vs, m_tick;
  logic [63:0] m_p1, m_p2, m_st;
  logic [15:0] m_cnt;
  logic        m_pend  [2][2];
  logic        m_have  [2][2];
  logic        m_atk_n [2][2];
  int          m_start [2][2];
  int          m_k;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vs = 1'b1; m_tick = 1'b0; m_p1 = '0; m_p2 = '0; m_st = '0; m_cnt = '0; m_k = 0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        m_pend[i][p] = 1'b0; m_have[i][p] = 1'b0; m_atk_n[i][p] = 1'b1; m_start[i][p] = 0;
      end
  endtask

  task automatic model_clk();
    logic b;
    logic req [2];
    b = m_vs && !iVS;
    req[0] = r1; req[1] = r2;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        if (b) begin
          if ((m_pend[i][p] || req[p]) &&
              (!m_have[i][p] || m_k >= m_start[i][p] + atk_c[i] + cool_c[i] + 1)) begin
            m_have[i][p]  = 1'b1;
            m_start[i][p] = m_k;
          end
          m_pend[i][p]  = 1'b0;
          m_atk_n[i][p] = !(m_have[i][p] && (m_k - m_start[i][p]) < atk_c[i]);
        end else if (req[p]) begin
          m_pend[i][p] = 1'b1;
        end
      end
    if (b) begin
      m_p1 = p1_in; m_p2 = p2_in; m_st = st_in; m_cnt = m_cnt + 16'd1; m_k++;
    end
    m_tick = b;
    m_vs   = iVS;
  endtask

  task automatic compare_all();
    check("a.p1VGA", a_p1, m_p1);           check("a.p2VGA", a_p2, m_p2);
    check("a.stageVGA", a_st, m_st);        check("a.frame_cnt", a_cnt, m_cnt);
    check("a.frame_tick", a_tick, m_tick);
    check("a.p1_atk_n", a_a1, m_atk_n[0][0]); check("a.p2_atk_n", a_a2, m_atk_n[0][1]);
    check("b.p1VGA", b_p1, m_p1);           check("b.p2VGA", b_p2, m_p2);
    check("b.stageVGA", b_st, m_st);        check("b.frame_cnt", b_cnt, m_cnt);
    check("b.frame_tick", b_tick, m_tick);
    check("b.p1_atk_n", b_a1, m_atk_n[1][0]); check("b.p2_atk_n", b_a2, m_atk_n[1][1]);
  endtask

  task automatic step();
    if (!rst_n) model_reset();
    else model_clk();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rand_in();
    p1_in = {$urandom, $urandom}; p2_in = {$urandom, $urandom}; st_in = {$urandom, $urandom};
    iVS = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1)); r2 = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_in();
    #1;
    model_reset();
    compare_all();
    repeat (3) begin
      rand_in();
      step();
    end
    iVS = 1'b1; r1 = 1'b0; r2 = 1'b0;
    rst_n = 1'b1;
  endtask

  // Request modes: 0 none, 1 pulse at frame start, 2 only in the boundary cycle, 3 held.
  task automatic frame(input int hi, input int lo, input int m1, input int m2);
    for (int c = 0; c < hi; c++) begin
      iVS = 1'b1;
      r1 = (m1 == 3) || (m1 == 1 && c == 0);
      r2 = (m2 == 3) || (m2 == 1 && c == 0);
      step();
    end
    iVS = 1'b0; r1 = (m1 == 2) || (m1 == 3); r2 = (m2 == 2) || (m2 == 3);
    step();
    r1 = (m1 == 3); r2 = (m2 == 3);
    for (int c = 1; c < lo; c++) step();
    r1 = 1'b0; r2 = 1'b0;
  endtask

  typedef struct {
    logic [63:0] p1, p2, st;
    int          m1, m2;
    logic        ea1, ea2, eb1, eb2;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    atk_c[0] = ATK0; cool_c[0] = COOL0; atk_c[1] = ATK1; cool_c[1] = COOL1;
    tbl[0] = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0001, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
    tbl[1] = '{64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[3] = '{64'h0000_0000_0000_0000, 64'hCAFE_F00D_0BAD_BEEF, 64'h0F0F_0F0F_0F0F_0F0F, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4};
    tbl[4] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5};
    tbl[5] = '{64'hDDDD_EEEE_FFFF_0000, 64'h0101_0101_0101_0101, 64'hFEFE_FEFE_FEFE_FEFE, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd6};

    rst_n = 1'b1; iVS = 1'b1; r1 = 1'b0; r2 = 1'b0; p1_in = '0; p2_in = '0; st_in = '0;
    #2;
    do_reset();

    // Table of one-frame vectors straight out of reset.
    for (int v = 0; v < 6; v++) begin
      p1_in = tbl[v].p1; p2_in = tbl[v].p2; st_in = tbl[v].st;
      frame(2, 2, tbl[v].m1, tbl[v].m2);
      check($sformatf("tbl%0d.p1VGA", v), a_p1, tbl[v].p1);
      check($sformatf("tbl%0d.p2VGA", v), a_p2, tbl[v].p2);
      check($sformatf("tbl%0d.stageVGA", v), a_st, tbl[v].st);
      check($sformatf("tbl%0d.frame_cnt", v), a_cnt, tbl[v].ecnt);
      check($sformatf("tbl%0d.a_atk", v), {a_a1, a_a2}, {tbl[v].ea1, tbl[v].ea2});
      check($sformatf("tbl%0d.b_atk", v), {b_a1, b_a2}, {tbl[v].eb1, tbl[v].eb2});
    end

    // Tear-free descriptor update.
    do_reset();
    p1_in = 64'h1111_1111_1111_1111;
    frame(2, 2, 0, 0);
    iVS = 1'b1; step();
    p1_in = 64'hDEAD_BEEF_0000_0001; step();
    check("t2.hold1", a_p1, 64'h1111_1111_1111_1111);
    step();
    check("t2.hold2", a_p1, 64'h1111_1111_1111_1111);
    iVS = 1'b0; step();
    check("t2.update", a_p1, 64'hDEAD_BEEF_0000_0001);
    check("t2.tick_hi", a_tick, 1'b1);
    p1_in = '0; step();
    check("t2.tick_lo", a_tick, 1'b0);
    check("t2.hold_low_vs", a_p1, 64'hDEAD_BEEF_0000_0001);

    // Single pulse: attack covers exactly ATK frames.
    do_reset();
    for (int f = 0; f < 16; f++) begin
      frame(2, 1, (f == 0) ? 1 : 0, 0);
      check($sformatf("t3.pulse.a%0d", f), a_a1, !(f < int'(ATK0)));
      check($sformatf("t3.pulse.b%0d", f), b_a1, !(f < int'(ATK1)));
      check($sformatf("t3.pulse.p2_%0d", f), a_a2, 1'b1);
    end

    // Request every frame / held level: re-arm only one frame after cooldown ends.
    for (int mode = 1; mode <= 3; mode += 2) begin
      do_reset();
      for (int f = 0; f < 45; f++) begin
        frame(3, 1, mode, (mode == 1) ? 1 : 0);
        check($sformatf("t4.m%0d.a%0d", mode, f), a_a1, !((f % int'(ATK0 + COOL0 + 1)) < int'(ATK0)));
        check($sformatf("t4.m%0d.b%0d", mode, f), b_a1, !((f % int'(ATK1 + COOL1 + 1)) < int'(ATK1)));
        check($sformatf("t5.m%0d.a2_%0d", mode, f), a_a2,
              (mode == 1) ? !((f % int'(ATK0 + COOL0 + 1)) < int'(ATK0)) : 1'b1);
      end
    end

    // Request only in the boundary cycle counts for that boundary.
    do_reset();
    frame(2, 1, 0, 0);
    frame(2, 1, 2, 0);
    check("t4.req_in_b.p1", a_a1, 1'b0);
    check("t4.req_in_b.p2", a_a2, 1'b1);

    // Frame counter wrap from a preloaded value.
    do_reset();
    frame(2, 1, 0, 0);
    iVS = 1'b1;
    force dut_a.fcnt_q = 16'hFFFE;
    force dut_b.fcnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step();
    release dut_a.fcnt_q;
    release dut_b.fcnt_q;
    step();
    frame(2, 1, 0, 0);
    check("t6.cnt_ffff", a_cnt, 16'hFFFF);
    frame(2, 1, 0, 0);
    check("t6.cnt_wrap", a_cnt, 16'h0000);
    check("t6.cnt_wrap_b", b_cnt, 16'h0000);

    // Asynchronous reset mid-attack with a request pending.
    do_reset();
    frame(2, 1, 1, 1);
    check("t6.attack_on", {a_a1, a_a2}, 2'b00);
    iVS = 1'b1; r1 = 1'b1; step();
    r1 = 1'b0; step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6.async_atk", {a_a1, a_a2, b_a1, b_a2}, 4'b1111);
    check("t6.async_desc", a_p1, 64'h0);
    check("t6.async_cnt", a_cnt, 16'h0);
    step();
    rst_n = 1'b1;
    frame(2, 1, 0, 0);
    check("t6.no_stale_req", {a_a1, a_a2}, 2'b11);
    check("t6.first_cnt", a_cnt, 16'd1);

    // Randomized frames, requests and descriptor traffic.
    do_reset();
    for (int f = 0; f < 300; f++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 5);
      lo = $urandom_range(1, 3);
      for (int c = 0; c < hi + lo; c++) begin
        iVS = (c < hi) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 2) == 0) p1_in = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) p2_in = {$urandom, $urandom};
        if ($urandom_range(0, 4) == 0) st_in = {$urandom, $urandom};
        r1 = ($urandom_range(0, 15) == 0);
        r2 = ($urandom_range(0, 9) == 0);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
